// File: rtl/dmem_access_ctrl.sv
// Purpose  : sequences one data-memory req/ack transaction per EXE/MEM load/store.
// Latency  : request issued the cycle after detect; load data + strobe the cycle after ack.
// Backpres.: stall freezes the upstream pipeline from detect until the DONE cycle.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   memread_in, memwrite_in          access request from the EXE/MEM register
//   addr_in, wdata_in                effective address and store data
//   stall                            combinational pipeline freeze
//   rdata_out, rdata_valid           load data and its one-cycle strobe to MEM/WB
//   mem_req/we/addr/wdata            registered request to the data memory
//   mem_ack, mem_rdata               memory completion pulse and read data
//   err, err_clr                     sticky timeout flag and its synchronous clear
module dmem_access_ctrl #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          memread_in,
  input  logic          memwrite_in,
  input  logic [AW-1:0] addr_in,
  input  logic [DW-1:0] wdata_in,
  output logic          stall,
  output logic [DW-1:0] rdata_out,
  output logic          rdata_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err,
  input  logic          err_clr
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          access;
  logic          acked;
  logic          timed_out;

  assign access    = memread_in | memwrite_in;
  assign acked     = (state == BUSY) && mem_ack;
  // An ack in the final BUSY cycle takes priority over the timeout.
  assign timed_out = (state == BUSY) && !mem_ack && (cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE never looks at the request inputs because they
  // still hold the instruction that just completed.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (access) state_nxt = BUSY;
      BUSY:    if (acked || timed_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. mem_we still holds the access type during DONE, so it
  // selects whether the completion carries load data. Stall is held low
  // while reset is asserted so a frozen pipeline cannot come out of reset.
  always_comb begin
    stall       = 1'b0;
    rdata_valid = 1'b0;
    unique case (state)
      IDLE:    stall = rst_n & access;
      BUSY:    stall = 1'b1;
      DONE:    rdata_valid = ~mem_we;
      default: stall = 1'b0;
    endcase
  end

  // Request and read-data datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_out <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            mem_req   <= 1'b1;
            mem_we    <= memwrite_in;  // read+write together is a write
            mem_addr  <= addr_in;
            mem_wdata <= wdata_in;
            cnt       <= '0;
          end
        end
        BUSY: begin
          if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
          if (acked) begin
            mem_req <= 1'b0;
            if (!mem_we) rdata_out <= mem_rdata;
          end else if (timed_out) begin
            mem_req <= 1'b0;
            if (!mem_we) rdata_out <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky timeout flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (timed_out) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Purpose  : randomized + directed bench for dmem_access_ctrl against a transaction-level model.
// Latency  : expects request the cycle after detect, completion the cycle after ack or timeout.
// Backpres.: bench holds the EXE/MEM inputs steady while the model says the pipeline is stalled.
module tb_dmem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memread_in, memwrite_in;
  logic [31:0] addr_in, wdata_in;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err, err_clr;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic        err_m;
  logic [31:0] rdata_m;
  bit          clr_en;

  dmem_access_ctrl #(.DW(32), .AW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .memread_in(memread_in), .memwrite_in(memwrite_in),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .stall(stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; the sticky-error model follows the rule "timeout sets,
  // otherwise a clear clears" using the err_clr level seen at this edge.
  task automatic step(input bit timeout_now);
    @(posedge clk);
    err_m = timeout_now | (err_m & ~err_clr);
    #1;
    err_clr = clr_en ? ($urandom_range(0, 7) == 0) : 1'b0;
  endtask

  // One non-memory instruction slot, optionally with a spurious ack.
  task automatic run_nop(input bit ack);
    memread_in  = 1'b0;
    memwrite_in = 1'b0;
    addr_in     = $urandom;
    wdata_in    = $urandom;
    mem_ack     = ack;
    mem_rdata   = $urandom;
    @(negedge clk);
    check("idle_stall", 32'(stall), 32'd0);
    check("idle_req",   32'(mem_req), 32'd0);
    check("idle_valid", 32'(rdata_valid), 32'd0);
    check("idle_rdata", rdata_out, rdata_m);
    check("idle_err",   32'(err), 32'(err_m));
    step(1'b0);
    mem_ack = 1'b0;
  endtask

  // One memory instruction. The memory acks in BUSY cycle k; k > TO means it never acks.
  task automatic run_mem(input bit rd, input bit wr, input int k,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat);
    logic [31:0] d;
    int          n;
    memread_in  = rd;
    memwrite_in = wr;
    addr_in     = a;
    wdata_in    = wd;
    @(negedge clk);
    check("detect_stall", 32'(stall), 32'd1);
    check("detect_req",   32'(mem_req), 32'd0);
    step(1'b0);
    n = (k <= TO) ? k : TO;
    d = 32'd0;
    for (int j = 1; j <= n; j++) begin
      mem_rdata = $urandom;
      if (j == k) begin
        mem_ack   = 1'b1;
        mem_rdata = rdat;
        d         = rdat;
      end
      @(negedge clk);
      check("busy_stall", 32'(stall), 32'd1);
      check("busy_req",   32'(mem_req), 32'd1);
      check("busy_we",    32'(mem_we), 32'(wr));
      check("busy_addr",  mem_addr, a);
      check("busy_wdata", mem_wdata, wd);
      step(k > TO && j == TO);
      mem_ack = 1'b0;
    end
    if (!wr) rdata_m = d;
    // A stray ack in DONE must not disturb anything.
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(negedge clk);
    check("done_stall", 32'(stall), 32'd0);
    check("done_req",   32'(mem_req), 32'd0);
    check("done_valid", 32'(rdata_valid), 32'(!wr));
    check("done_rdata", rdata_out, rdata_m);
    check("done_err",   32'(err), 32'(err_m));
    step(1'b0);
    mem_ack = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    err_clr = 1'b0;
    clr_en  = 1'b0;
    err_m   = 1'b0;
    rdata_m = 32'd0;
    mem_ack = 1'b0;

    // Reset held with random inputs: every output must be zero.
    for (int i = 0; i < 4; i++) begin
      memread_in  = 1'($urandom);
      memwrite_in = 1'($urandom);
      addr_in     = $urandom;
      wdata_in    = $urandom;
      mem_ack     = 1'($urandom);
      mem_rdata   = $urandom;
      err_clr     = 1'($urandom);
      @(negedge clk);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_rdata", rdata_out, 32'd0);
      check("rst_valid", 32'(rdata_valid), 32'd0);
      check("rst_req",   32'(mem_req), 32'd0);
      check("rst_we",    32'(mem_we), 32'd0);
      check("rst_addr",  mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_err",   32'(err), 32'd0);
    end
    memread_in  = 1'b0;
    memwrite_in = 1'b0;
    mem_ack     = 1'b0;
    err_clr     = 1'b0;
    rst_n       = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    repeat (3) run_nop(1'b0);
    run_mem(1'b1, 1'b0, 3, 32'h100, $urandom, 32'hCAFEF00D);
    run_mem(1'b0, 1'b1, 1, 32'h40, 32'h12345678, $urandom);
    run_nop(1'b1);
    run_nop(1'b0);
    run_mem(1'b1, 1'b0, TO + 1, $urandom, $urandom, $urandom);
    err_clr = 1'b1;
    run_nop(1'b0);
    run_nop(1'b0);
    run_mem(1'b1, 1'b0, TO, $urandom, $urandom, $urandom);
    run_mem(1'b1, 1'b0, 1, $urandom, $urandom, $urandom);
    run_mem(1'b1, 1'b0, 1, $urandom, $urandom, $urandom);
    run_mem(1'b1, 1'b1, 2, $urandom, $urandom, $urandom);

    // Random instruction stream with random ack delays and err_clr pulses
    clr_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) run_nop(1'($urandom_range(0, 1)));
      else run_mem(kind[0], kind[1], $urandom_range(1, TO + 2), $urandom, $urandom, $urandom);
    end
    clr_en  = 1'b0;
    err_clr = 1'b0;
    run_nop(1'b0);

    // Reset in the middle of a transaction, then a late ack
    memread_in = 1'b1;
    addr_in    = $urandom;
    @(negedge clk);
    step(1'b0);
    @(negedge clk);
    step(1'b0);
    #2;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_req_async", 32'(mem_req), 32'd0);
    memread_in = 1'b0;
    err_m      = 1'b0;
    rdata_m    = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = $urandom;
    @(negedge clk);
    check("late_ack_stall", 32'(stall), 32'd0);
    check("late_ack_req",   32'(mem_req), 32'd0);
    step(1'b0);
    mem_ack = 1'b0;
    run_nop(1'b0);
    run_nop(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
